// File: rtl/hazard_controller.sv
// Stall/flush sequencer for the 5-stage RV32I pipeline: load-use, taken-branch and
// multi-cycle data-memory hazards, plus a memory-timeout watchdog and perf counters.
module hazard_controller #(
    parameter int unsigned REG_ADDR_W  = 5,
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_uses_rs2,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_mem_read,
    input  logic                  ex_branch_taken,
    input  logic                  mem_req,
    input  logic                  mem_ready,
    output logic                  pc_write,
    output logic                  if_id_write,
    output logic                  if_id_flush,
    output logic                  id_ex_write,
    output logic                  id_ex_flush,
    output logic                  ex_mem_write,
    output logic                  mem_wb_flush,
    output logic                  mem_err,
    output logic [1:0]            state,
    output logic [CNT_W-1:0]      stall_cycles,
    output logic [CNT_W-1:0]      flush_count
);

    localparam int unsigned           WAIT_W     = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0]     WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        LU_STALL = 2'd2,
        HALT     = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              mem_err_q, mem_err_d;
    logic [CNT_W-1:0]  stall_q, flush_q;
    logic              flush_evt, stall_evt;
    logic              mem_hazard, lu_hazard;

    assign mem_hazard = mem_req & ~mem_ready;
    assign lu_hazard  = id_valid & ex_mem_read & (ex_rd != '0) &
                        ((ex_rd == id_rs1) | (id_uses_rs2 & (ex_rd == id_rs2)));

    always_comb begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_write  = 1'b1;
        id_ex_flush  = 1'b0;
        ex_mem_write = 1'b1;
        mem_wb_flush = 1'b0;
        state_d      = state_q;
        wait_d       = wait_q;
        mem_err_d    = mem_err_q;
        flush_evt    = 1'b0;
        // Outputs stay at their defaults for the whole reset cycle.
        if (!reset) begin
            case (state_q)
                RUN, LU_STALL: begin
                    if (mem_hazard) begin
                        pc_write     = 1'b0;
                        if_id_write  = 1'b0;
                        id_ex_write  = 1'b0;
                        ex_mem_write = 1'b0;
                        mem_wb_flush = 1'b1;
                        state_d      = MEM_WAIT;
                        wait_d       = WAIT_W'(1);
                    end else if (ex_branch_taken) begin
                        if_id_flush = 1'b1;
                        id_ex_flush = 1'b1;
                        flush_evt   = 1'b1;
                        state_d     = RUN;
                    end else if (lu_hazard && state_q == RUN) begin
                        pc_write    = 1'b0;
                        if_id_write = 1'b0;
                        id_ex_flush = 1'b1;
                        state_d     = LU_STALL;
                    end else begin
                        state_d = RUN;
                    end
                end
                MEM_WAIT: begin
                    if (!mem_ready) begin
                        pc_write     = 1'b0;
                        if_id_write  = 1'b0;
                        id_ex_write  = 1'b0;
                        ex_mem_write = 1'b0;
                        mem_wb_flush = 1'b1;
                        if (wait_q >= WAIT_LIMIT) begin
                            state_d   = HALT;
                            mem_err_d = 1'b1;
                        end else begin
                            wait_d = wait_q + WAIT_W'(1);
                        end
                    end else begin
                        state_d = RUN;
                        wait_d  = '0;
                        if (ex_branch_taken) begin
                            if_id_flush = 1'b1;
                            id_ex_flush = 1'b1;
                            flush_evt   = 1'b1;
                        end
                    end
                end
                default: begin
                    pc_write     = 1'b0;
                    if_id_write  = 1'b0;
                    id_ex_write  = 1'b0;
                    ex_mem_write = 1'b0;
                    id_ex_flush  = 1'b1;
                    mem_wb_flush = 1'b1;
                end
            endcase
        end
    end

    assign stall_evt = (state_q != HALT) && !pc_write;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= RUN;
            wait_q    <= '0;
            mem_err_q <= 1'b0;
            stall_q   <= '0;
            flush_q   <= '0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            mem_err_q <= mem_err_d;
            if (stall_evt && stall_q != '1) begin
                stall_q <= stall_q + CNT_W'(1);
            end
            if (flush_evt && flush_q != '1) begin
                flush_q <= flush_q + CNT_W'(1);
            end
        end
    end

    assign mem_err      = mem_err_q;
    assign state        = state_q;
    assign stall_cycles = stall_q;
    assign flush_count  = flush_q;

endmodule

// File: tb/tb_hazard_controller.sv
// Self-checking bench for hazard_controller: directed hazard scenarios plus a
// randomized run, all compared against a rule-level reference model.
module tb_hazard_controller;

    localparam int RW = 5;
    localparam int CW = 32;
    localparam int TO = 4;
    localparam longint CMAX = (64'd1 << CW) - 1;

    // Control vector order: pc_write, if_id_write, if_id_flush, id_ex_write,
    // id_ex_flush, ex_mem_write, mem_wb_flush.
    localparam logic [6:0] DEF = 7'b1101010;
    localparam logic [6:0] FRZ = 7'b0000001;
    localparam logic [6:0] FLS = 7'b1111110;
    localparam logic [6:0] LUV = 7'b0001110;
    localparam logic [6:0] HLT = 7'b0000101;

    logic clk = 1'b0;
    logic reset;
    logic id_valid, id_uses_rs2, ex_mem_read, ex_branch_taken, mem_req, mem_ready;
    logic [RW-1:0] id_rs1, id_rs2, ex_rd;
    logic pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush;
    logic ex_mem_write, mem_wb_flush, mem_err;
    logic [1:0] state;
    logic [CW-1:0] stall_cycles, flush_count;
    logic [6:0] ctrl;

    int total = 0;
    int bad   = 0;

    int     m_state = 0;
    int     m_wait  = 0;
    bit     m_err   = 1'b0;
    longint m_stall = 0;
    longint m_flush = 0;

    always #5 clk = ~clk;

    hazard_controller #(.REG_ADDR_W(RW), .CNT_W(CW), .MEM_TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs2(id_uses_rs2),
        .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
        .id_ex_write(id_ex_write), .id_ex_flush(id_ex_flush), .ex_mem_write(ex_mem_write),
        .mem_wb_flush(mem_wb_flush), .mem_err(mem_err), .state(state),
        .stall_cycles(stall_cycles), .flush_count(flush_count)
    );

    assign ctrl = {pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush,
                   ex_mem_write, mem_wb_flush};

    function automatic logic lu_hit();
        return id_valid && ex_mem_read && ex_rd != 0 &&
               (ex_rd == id_rs1 || (id_uses_rs2 && ex_rd == id_rs2));
    endfunction

    // Expected controls from the hazard priority rules.
    function automatic logic [6:0] model_ctrl();
        if (reset) return DEF;
        if (m_state == 3) return HLT;
        if (m_state == 1 ? !mem_ready : (mem_req && !mem_ready)) return FRZ;
        if (ex_branch_taken) return FLS;
        if (m_state == 0 && lu_hit()) return LUV;
        return DEF;
    endfunction

    task automatic model_clock();
        logic [6:0] c;
        c = model_ctrl();
        if (reset) begin
            m_state = 0; m_wait = 0; m_err = 1'b0; m_stall = 0; m_flush = 0;
            return;
        end
        if (m_state == 3) return;
        if (!c[6] && m_stall < CMAX) m_stall++;
        if (c == FLS && m_flush < CMAX) m_flush++;
        if (m_state == 1) begin
            if (mem_ready) m_state = 0;
            else if (m_wait >= TO) begin m_state = 3; m_err = 1'b1; end
            else m_wait++;
        end else if (mem_req && !mem_ready) begin
            m_state = 1; m_wait = 1;
        end else if (!ex_branch_taken && m_state == 0 && lu_hit()) begin
            m_state = 2;
        end else begin
            m_state = 0;
        end
    endtask

    task automatic clear_in();
        id_valid = 0; id_rs1 = '0; id_rs2 = '0; id_uses_rs2 = 0; ex_rd = '0;
        ex_mem_read = 0; ex_branch_taken = 0; mem_req = 0; mem_ready = 0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_in();
        @(posedge clk); model_clock(); #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; clear_in();
        mem_req = 1; ex_branch_taken = 1;
        @(negedge clk);
        total++;
        if (ctrl !== DEF) begin bad++; $display("FAIL reset_ctrl got=%b exp=%b", ctrl, DEF); end
        @(posedge clk); model_clock(); #1;
        reset = 1'b0; clear_in();
        @(negedge clk);
        total++;
        if (state !== 2'd0 || mem_err !== 1'b0 || stall_cycles !== '0 || flush_count !== '0)
        begin
            bad++;
            $display("FAIL reset_state got st=%0d err=%b stall=%0d flush=%0d exp 0/0/0/0",
                     state, mem_err, stall_cycles, flush_count);
        end
        @(posedge clk); model_clock(); #1;
    endtask

    task automatic test_load_use();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            clear_in();
            if (i < 2) begin id_valid = 1; ex_mem_read = 1; ex_rd = 5'd5; id_rs1 = 5'd5; end
            @(negedge clk);
            total++;
            if (ctrl !== model_ctrl() || state !== m_state[1:0] || stall_cycles !== m_stall[CW-1:0])
            begin
                bad++;
                $display("FAIL load_use_model c%0d got ctrl=%b st=%0d stall=%0d exp ctrl=%b st=%0d stall=%0d",
                         i, ctrl, state, stall_cycles, model_ctrl(), m_state, m_stall);
            end
            total++;
            case (i)
                0: if (pc_write !== 0 || id_ex_flush !== 1 || state !== 0) begin
                       bad++; $display("FAIL load_use_c0 got pc=%b idf=%b st=%0d exp 0/1/0", pc_write, id_ex_flush, state);
                   end
                1: if (state !== 2 || pc_write !== 1) begin
                       bad++; $display("FAIL load_use_c1 got st=%0d pc=%b exp 2/1", state, pc_write);
                   end
                default: if (state !== 0 || stall_cycles !== 1) begin
                       bad++; $display("FAIL load_use_end got st=%0d stall=%0d exp 0/1", state, stall_cycles);
                   end
            endcase
            @(posedge clk); model_clock(); #1;
        end
    endtask

    task automatic test_no_stall();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            clear_in();
            if (i == 0) begin id_valid = 1; ex_mem_read = 1; ex_rd = '0; id_rs1 = '0; end
            if (i == 1) begin id_valid = 1; ex_mem_read = 1; ex_rd = 5'd7; id_rs2 = 5'd7; id_rs1 = 5'd3; end
            @(negedge clk);
            total++;
            if (ctrl !== DEF || state !== 0 || stall_cycles !== 0) begin
                bad++;
                $display("FAIL no_stall c%0d got ctrl=%b st=%0d stall=%0d exp ctrl=%b st=0 stall=0",
                         i, ctrl, state, stall_cycles, DEF);
            end
            @(posedge clk); model_clock(); #1;
        end
    endtask

    task automatic test_branch();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            clear_in();
            if (i < 2) ex_branch_taken = 1;
            if (i == 1) begin id_valid = 1; ex_mem_read = 1; ex_rd = 5'd9; id_rs1 = 5'd9; end
            @(negedge clk);
            total++;
            if (ctrl !== model_ctrl() || flush_count !== m_flush[CW-1:0] || state !== m_state[1:0]) begin
                bad++;
                $display("FAIL branch_model c%0d got ctrl=%b flush=%0d st=%0d exp ctrl=%b flush=%0d st=%0d",
                         i, ctrl, flush_count, state, model_ctrl(), m_flush, m_state);
            end
            total++;
            if ((i < 2 && ctrl !== FLS) || flush_count !== i || stall_cycles !== 0 || state !== 0) begin
                bad++;
                $display("FAIL branch_c%0d got ctrl=%b flush=%0d stall=%0d st=%0d exp flush=%0d",
                         i, ctrl, flush_count, stall_cycles, state, i);
            end
            @(posedge clk); model_clock(); #1;
        end
    endtask

    task automatic test_mem_wait();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            clear_in();
            if (i < 4) mem_req = 1;
            mem_ready = (i == 3);
            @(negedge clk);
            total++;
            if (ctrl !== model_ctrl() || state !== m_state[1:0] || stall_cycles !== m_stall[CW-1:0]) begin
                bad++;
                $display("FAIL mem_wait_model c%0d got ctrl=%b st=%0d stall=%0d exp ctrl=%b st=%0d stall=%0d",
                         i, ctrl, state, stall_cycles, model_ctrl(), m_state, m_stall);
            end
            total++;
            case (i)
                0, 1, 2: if (ctrl !== FRZ || state !== (i == 0 ? 0 : 1)) begin
                       bad++; $display("FAIL mem_wait_freeze c%0d got ctrl=%b st=%0d exp ctrl=%b", i, ctrl, state, FRZ);
                   end
                3: if (ctrl !== DEF || state !== 1) begin
                       bad++; $display("FAIL mem_wait_release got ctrl=%b st=%0d exp ctrl=%b st=1", ctrl, state, DEF);
                   end
                default: if (state !== 0 || stall_cycles !== 3) begin
                       bad++; $display("FAIL mem_wait_end got st=%0d stall=%0d exp 0/3", state, stall_cycles);
                   end
            endcase
            @(posedge clk); model_clock(); #1;
        end
    endtask

    task automatic test_timeout();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            clear_in();
            mem_req = 1; mem_ready = 0;
            @(negedge clk);
            total++;
            if (ctrl !== model_ctrl() || state !== m_state[1:0] || mem_err !== m_err) begin
                bad++;
                $display("FAIL timeout_model c%0d got ctrl=%b st=%0d err=%b exp ctrl=%b st=%0d err=%b",
                         i, ctrl, state, mem_err, model_ctrl(), m_state, m_err);
            end
            if (i >= 5) begin
                total++;
                if (state !== 3 || mem_err !== 1 || ctrl !== HLT || stall_cycles !== 5) begin
                    bad++;
                    $display("FAIL timeout_halt c%0d got st=%0d err=%b ctrl=%b stall=%0d exp 3/1/%b/5",
                             i, state, mem_err, ctrl, stall_cycles, HLT);
                end
            end
            @(posedge clk); model_clock(); #1;
        end
        do_reset();
        @(negedge clk);
        total++;
        if (state !== 0 || mem_err !== 0 || stall_cycles !== 0 || flush_count !== 0) begin
            bad++;
            $display("FAIL timeout_reset got st=%0d err=%b stall=%0d flush=%0d exp all 0",
                     state, mem_err, stall_cycles, flush_count);
        end
        @(posedge clk); model_clock(); #1;
    endtask

    task automatic test_priority();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            clear_in();
            if (i < 3) begin mem_req = 1; ex_branch_taken = 1; end
            mem_ready = (i == 2);
            @(negedge clk);
            total++;
            if (ctrl !== model_ctrl() || flush_count !== m_flush[CW-1:0] || state !== m_state[1:0]) begin
                bad++;
                $display("FAIL priority_model c%0d got ctrl=%b flush=%0d st=%0d exp ctrl=%b flush=%0d st=%0d",
                         i, ctrl, flush_count, state, model_ctrl(), m_flush, m_state);
            end
            total++;
            case (i)
                0, 1: if (ctrl !== FRZ || flush_count !== 0) begin
                       bad++; $display("FAIL priority_freeze c%0d got ctrl=%b flush=%0d exp %b/0", i, ctrl, flush_count, FRZ);
                   end
                2: if (ctrl !== FLS) begin
                       bad++; $display("FAIL priority_release got ctrl=%b exp %b", ctrl, FLS);
                   end
                default: if (flush_count !== 1 || state !== 0) begin
                       bad++; $display("FAIL priority_end got flush=%0d st=%0d exp 1/0", flush_count, state);
                   end
            endcase
            @(posedge clk); model_clock(); #1;
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            reset           = ($urandom_range(0, 99) == 0);
            id_valid        = ($urandom_range(0, 3) != 0);
            id_rs1          = RW'($urandom_range(0, 3));
            id_rs2          = RW'($urandom_range(0, 3));
            id_uses_rs2     = $urandom_range(0, 1) == 1;
            ex_rd           = RW'($urandom_range(0, 3));
            ex_mem_read     = $urandom_range(0, 1) == 1;
            ex_branch_taken = ($urandom_range(0, 5) == 0);
            mem_req         = ($urandom_range(0, 2) == 0);
            mem_ready       = $urandom_range(0, 1) == 1;
            @(negedge clk);
            total++;
            if (ctrl !== model_ctrl() || state !== m_state[1:0] || mem_err !== m_err ||
                stall_cycles !== m_stall[CW-1:0] || flush_count !== m_flush[CW-1:0]) begin
                bad++;
                $display("FAIL random c%0d got ctrl=%b st=%0d err=%b stall=%0d flush=%0d exp ctrl=%b st=%0d err=%b stall=%0d flush=%0d",
                         i, ctrl, state, mem_err, stall_cycles, flush_count,
                         model_ctrl(), m_state, m_err, m_stall, m_flush);
            end
            @(posedge clk); model_clock(); #1;
        end
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        clear_in();
        test_reset();
        test_load_use();
        test_no_stall();
        test_branch();
        test_mem_wait();
        test_timeout();
        test_priority();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
